// File: rtl/rv32e_io_port.sv
// Memory-mapped GPIO port: synchronized input pins with change flag/interrupt,
// and a software-driven output register with set/clear/toggle aliases.
module rv32e_io_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       addr,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             irq,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o
);

    localparam logic [2:0] REG_IN     = 3'd0;
    localparam logic [2:0] REG_OUT    = 3'd1;
    localparam logic [2:0] REG_SET    = 3'd2;
    localparam logic [2:0] REG_CLR    = 3'd3;
    localparam logic [2:0] REG_TGL    = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] in_prev_q, in_prev_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             chg_q, chg_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] wdata;
    logic [2:0]       reg_sel;
    logic             change;
    logic             chg_clr;
    logic             unused_bits;

    assign in_sync     = sync_q[SYNC_STAGES-1];
    assign wdata       = wr_data[WIDTH-1:0];
    assign reg_sel     = addr[4:2];
    assign change      = (in_sync != in_prev_q);
    assign unused_bits = ^{addr[1:0], wr_data};

    always_comb begin
        sync_d[0] = i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        in_prev_d = in_sync;
    end

    always_comb begin
        o_d      = o_q;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            unique case (reg_sel)
                REG_OUT:  o_d      = wdata;
                REG_SET:  o_d      = o_q | wdata;
                REG_CLR:  o_d      = o_q & ~wdata;
                REG_TGL:  o_d      = o_q ^ wdata;
                REG_CTRL: irq_en_d = wr_data[0];
                default:  ;
            endcase
        end
    end

    // A new change event always beats a clear arriving at the same edge.
    always_comb begin
        chg_clr = (rd_en && reg_sel == REG_IN) ||
                  (wr_en && reg_sel == REG_STATUS && wr_data[0]);
        chg_d   = change | (chg_q & ~chg_clr);
        irq_d   = chg_d & irq_en_d;
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            unique case (reg_sel)
                REG_IN:     rd_data_d[WIDTH-1:0] = in_sync;
                REG_OUT:    rd_data_d[WIDTH-1:0] = o_q;
                REG_STATUS: rd_data_d[0]         = chg_q;
                REG_CTRL:   rd_data_d[0]         = irq_en_q;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            in_prev_q  <= '0;
            o_q        <= '0;
            chg_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            in_prev_q  <= in_prev_d;
            o_q        <= o_d;
            chg_q      <= chg_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o        = o_q;
    assign irq      = irq_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: doc/rv32e_io_port.md
Name: rv32e_io_port

Overview:
- Memory-mapped 8-bit I/O peripheral inside rv32e_soc, between the core's data bus and the SoC-level i/o pins.
- Receive path: synchronizes external input i, exposes it to software and flags changes.
- Transmit path: drives output o from a software-writable register with set/clear/toggle access, so firmware can run pin-level handshakes, e.g. o[0] as a "value loaded" strobe.

Parameters:
- WIDTH, 8, width of the i and o pin buses (1..32).
- SYNC_STAGES, 2, flop stages on input i (>=2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- addr  input  5  byte offset within the peripheral; bits [1:0] ignored.
- wr_en  input  1  write strobe, one cycle per write.
- wr_data  input  32  write data; only low WIDTH bits used, except STATUS/CTRL.
- rd_en  input  1  read strobe, one cycle per read.
- rd_data  output  32  registered read data.
- rd_valid  output  1  high one cycle after rd_en.
- irq  output  1  level interrupt = CHG & IRQ_EN.
- i  input  WIDTH  external input pins, asynchronous.
- o  output  WIDTH  external output pins, registered.

Behaviour:
- Reset is synchronous: one clk edge with reset=1 clears everything.
  - Cleared: o, rd_data, rd_valid, irq, CHG, IRQ_EN, all sync flops, in_prev.
- Reset mid-transaction: any pending rd_valid is dropped; a write in the reset cycle is ignored.
- Input path:
  - i passes through SYNC_STAGES flops to give in_sync; in_prev <= in_sync every cycle.
  - change = (in_sync != in_prev). CHG is set at the edge where change is 1.
  - A change on i sets CHG SYNC_STAGES+1 edges later (3 with the default).
  - A nonzero i at reset release produces one CHG set, by design.
- Register map (word offsets):
  - 0x00 IN: read-only; returns in_sync zero-extended. A read clears CHG at the same edge that captures rd_data.
  - 0x04 OUT: read/write; o <= wr_data[WIDTH-1:0].
  - 0x08 OUT_SET: write-only; o <= o | data.
  - 0x0C OUT_CLR: write-only; o <= o & ~data.
  - 0x10 OUT_TGL: write-only; o <= o ^ data.
  - 0x14 STATUS: bit0 CHG; reads return it; writing 1 to bit0 clears CHG, writing 0 has no effect.
  - 0x18 CTRL: bit0 IRQ_EN; read/write.
  - Write-only registers read 0.
  - Unmapped offsets (0x1C) read 0; writes to them are ignored.
- Timing:
  - Writes take effect at the posedge where wr_en=1. o changes one cycle after the write strobe.
  - Reads: rd_data and rd_valid are registered, one-cycle latency.
  - rd_valid is high exactly one cycle per rd_en; back-to-back reads are allowed every cycle.
  - rd_data holds its last value while rd_valid=0.
- Simultaneous events:
  - rd_en and wr_en in the same cycle (any addresses): the read returns the pre-write value; the write is applied at the same edge.
  - A CHG set (change=1) in the same cycle as a CHG clear (IN read or STATUS W1C): set wins, CHG stays 1.
  - irq is registered from the next-state CHG & IRQ_EN, so it tracks CHG with no extra cycle.
- Bits above WIDTH in rd_data are always 0.

Test Plan:
- Reset: hold reset=1 for 2 edges with i=0x07 -> o=0x00, irq=0, rd_valid=0. Release reset -> CHG=1 exactly 3 edges later.
- Input read and flag: CTRL=1, then i=0x07 -> irq=1 after 3 edges. Read 0x00 -> next cycle rd_valid=1, rd_data=0x00000007; irq=0 the following cycle.
- Output ops:
  - Write OUT=0x01 -> o=0x01.
  - OUT_SET 0x08 -> o=0x09.
  - OUT_CLR 0x01 -> o=0x08.
  - OUT_TGL 0x0A -> o=0x02, the firmware result 9-7.
  - Read 0x04 -> rd_data=0x00000002.
- Handshake emulation: firmware-style sequence of i=7, read IN, OUT_SET 1, OUT_CLR 1, i=9, read IN -> o[0] pulses high for exactly the programmed cycles; second IN read returns 9.
- Race: i changes 0x09->0x0B in the cycle in_sync updates while a STATUS W1C write lands on the same edge -> CHG remains 1.
- Misc: a read to 0x1C returns 0 with rd_valid; a write to 0x1C leaves o unchanged. Reset asserted the cycle after rd_en -> rd_valid stays 0 and o returns to 0x00.
